trace_buffer: RTL and testbench
===============================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one captured sample (e.g. {pc, op}).
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, log2 of buffer entries (DEPTH = 2**DEPTH_LOG2).
REQ-003 SHALL have parameter POST_TRIG, default 16, samples captured after the trigger sample.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port arm  input  1  one-cycle pulse that clears the buffer and starts capture.
REQ-007 SHALL have port capture_en  input  1  capture_data is a valid sample this cycle (e.g. CPU in EXECUTE).
REQ-008 SHALL have port capture_data  input  DATA_W  sample payload.
REQ-009 SHALL have port trigger  input  1  stop condition (e.g. halt/trap).
REQ-010 SHALL have port rd_req  input  1  pop the oldest stored entry.
REQ-011 SHALL have port rd_data  output  DATA_W (+16 with TRACE_TIMESTAMP_EN)  popped entry.
REQ-012 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-013 SHALL have ports state (output, 2: IDLE=0, ARMED=1, POST=2, DONE=3), count (output, DEPTH_LOG2+1: entries held) and wrapped (output, 1: oldest data overwritten).

Function
REQ-014 SHALL, in IDLE, ignore capture_en, trigger and rd_req; arm -> ARMED, count=0, wrapped=0, write pointer=0.
REQ-015 SHALL, in ARMED/POST, write capture_data at write pointer on each capture_en cycle; pointer increments modulo DEPTH.
REQ-016 SHALL saturate count at DEPTH; a write with count==DEPTH overwrites the oldest entry and sets wrapped=1.
REQ-017 SHALL, in ARMED, on trigger&capture_en, store that sample as the trigger sample, zero the post counter, -> POST (or DONE if POST_TRIG==0).
REQ-018 SHALL, in ARMED, on trigger without capture_en, -> POST with post counter zero, nothing stored.
REQ-019 SHALL, in POST, increment the post counter per stored sample and -> DONE the cycle the POST_TRIG-th sample is written; trigger in POST ignored.
REQ-020 SHALL permit POST_TRIG >= DEPTH; pre-trigger and trigger samples are then overwritten normally.
REQ-021 SHALL, in DONE, freeze the buffer; rd_req with count>0 yields rd_valid=1 and oldest entry on rd_data exactly one cycle later (sync RAM read); count decrements.
REQ-022 SHALL read oldest-first: start at write pointer if wrapped, else at 0; read pointer wraps modulo DEPTH.
REQ-023 SHALL -> IDLE the cycle after the final entry's rd_valid; rd_req with count==0 or outside DONE gives no rd_valid.
REQ-024 SHALL give arm priority over every other input in any non-reset state: restart as REQ-014, pending read discarded.

Reset
REQ-025 SHALL on reset: state=IDLE, count=0, wrapped=0, rd_valid=0, rd_data=0, pointers and post counter 0; reset overrides arm.
REQ-026 SHALL not clear RAM contents on reset; reset mid-capture or mid-readout abandons the operation.

Configuration
REQ-027 SHALL, with TRACE_TIMESTAMP_EN defined, keep a 16-bit free-running cycle counter (cleared by reset and arm, wraps at 0xFFFF) and store it as rd_data[DATA_W+15:DATA_W] with each sample.
REQ-028 SHALL, without TRACE_TIMESTAMP_EN, have rd_data exactly DATA_W bits, no counter logic.

Verification (DATA_W=32, DEPTH_LOG2=3, POST_TRIG=2)
REQ-029 SHALL cover: arm, 5 samples 0x1..0x5, trigger with 0x6, samples 0x7,0x8 -> DONE, count=8, wrapped=0; 8 reads return 0x1..0x8 in order, then IDLE.
REQ-030 SHALL cover: arm, 12 samples 0x1..0xC with trigger on 0xA -> DONE after 0xC, wrapped=1, count=8; reads return 0x5..0xC.
REQ-031 SHALL cover: trigger in IDLE and rd_req in ARMED -> no state change, rd_valid stays 0.
REQ-032 SHALL cover: reset asserted during POST after 3 samples -> next cycle state=0, count=0; new arm captures from address 0.
REQ-033 SHALL cover: arm asserted in DONE after 2 of 8 reads -> ARMED, count=0, no further rd_valid.
REQ-034 SHALL cover (TRACE_TIMESTAMP_EN): arm, samples on cycles 3 and 7 after arm -> timestamps 3 and 7.

Source files
------------

// File: rtl/trace_buffer.sv
// trace_buffer: arm/trigger capture ring buffer with oldest-first readout.
// Optional TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp above each sample.
module trace_buffer #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int POST_TRIG  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              capture_en,
  input  logic [DATA_W-1:0] capture_data,
  input  logic              trigger,
  input  logic              rd_req,
`ifdef TRACE_TIMESTAMP_EN
  output logic [DATA_W+15:0] rd_data,
`else
  output logic [DATA_W-1:0]  rd_data,
`endif
  output logic              rd_valid,
  output logic [1:0]        state,
  output logic [DEPTH_LOG2:0] count,
  output logic              wrapped
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
`ifdef TRACE_TIMESTAMP_EN
  localparam int RW    = DATA_W + 16;
`else
  localparam int RW    = DATA_W;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_n;

  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] wdata;
  logic [AW-1:0] wptr;
  logic [AW-1:0] raddr;
  logic [31:0]   post_cnt;
  logic          we;
  logic          re;
  logic          full;
  logic          last_post;

  assign state = state_q;
  assign we    = (state_q == ARMED || state_q == POST) && capture_en && !arm;
  assign re    = (state_q == DONE) && rd_req && (count != '0) && !arm;
  assign full  = (count == CW'(DEPTH));
  assign last_post = (state_q == POST) && capture_en &&
                     (post_cnt + 32'd1 == 32'(POST_TRIG));

  // Oldest entry sits count slots behind the (frozen) write pointer.
  assign raddr = wptr - count[AW-1:0];

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] stamp;

  // Free-running stamp; the arm cycle itself counts as cycle 0.
  always_ff @(posedge clk) begin
    if (reset)    stamp <= 16'd0;
    else if (arm) stamp <= 16'd1;
    else          stamp <= stamp + 16'd1;
  end

  assign wdata = {stamp, capture_data};
`else
  assign wdata = capture_data;
`endif

  // Sample RAM: write-only during capture, never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= wdata;
  end

  // Pointers, occupancy, post-trigger count and registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      count    <= '0;
      wrapped  <= 1'b0;
      post_cnt <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (arm) begin
      wptr     <= '0;
      count    <= '0;
      wrapped  <= 1'b0;
      post_cnt <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= re;
      if (re) begin
        rd_data <= mem[raddr];
        count   <= count - 1'b1;
      end
      if (we) begin
        wptr <= wptr + 1'b1;
        if (full) wrapped <= 1'b1;
        else      count   <= count + 1'b1;
      end
      if (state_q == ARMED && trigger)
        post_cnt <= '0;
      else if (state_q == POST && we)
        post_cnt <= post_cnt + 32'd1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state logic; arm restarts capture from any state.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (arm) state_n = ARMED;
      end
      ARMED: begin
        if (arm)
          state_n = ARMED;
        else if (trigger)
          state_n = (POST_TRIG == 0) ? DONE : POST;
      end
      POST: begin
        if (arm)            state_n = ARMED;
        else if (last_post) state_n = DONE;
      end
      DONE: begin
        if (arm)
          state_n = ARMED;
        else if (rd_valid && count == '0)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: directed checks of capture, wrap, readout and restart.
// Inputs change 1ns after each rising edge; outputs are checked there.
module tb_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        capture_en = 1'b0;
  logic [31:0] capture_data = '0;
  logic        trigger = 1'b0;
  logic        rd_req = 1'b0;
`ifdef TRACE_TIMESTAMP_EN
  logic [47:0] rd_data;
`else
  logic [31:0] rd_data;
`endif
  logic        rd_valid;
  logic [1:0]  state;
  logic [3:0]  count;
  logic        wrapped;

  int n_tests = 0;
  int n_fail  = 0;

  trace_buffer #(
    .DATA_W(32),
    .DEPTH_LOG2(3),
    .POST_TRIG(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .arm(arm),
    .capture_en(capture_en),
    .capture_data(capture_data),
    .trigger(trigger),
    .rd_req(rd_req),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .state(state),
    .count(count),
    .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic sample(input logic [31:0] d, input logic trig);
    capture_en   = 1'b1;
    capture_data = d;
    trigger      = trig;
    tick();
    capture_en   = 1'b0;
    trigger      = 1'b0;
  endtask

  // Pops n entries back to back, expecting first, first+1, ...
  task automatic read_run(input string tag, input int n,
                          input logic [31:0] first);
    rd_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_vld"}, 64'(rd_valid), 64'd1);
      check({tag, "_dat"}, 64'(rd_data[31:0]), 64'(first + 32'(i)));
    end
    rd_req = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_wrap", 64'(wrapped), 64'd0);
    check("rst_vld", 64'(rd_valid), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);

    // Trigger and read request in IDLE are ignored
    trigger = 1'b1;
    rd_req  = 1'b1;
    tick();
    trigger = 1'b0;
    rd_req  = 1'b0;
    check("idle_trig_state", 64'(state), 64'd0);
    check("idle_rd_vld", 64'(rd_valid), 64'd0);

    // Basic capture, no wrap
    do_arm();
    check("arm_state", 64'(state), 64'd1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("armed_rd_state", 64'(state), 64'd1);
    check("armed_rd_vld", 64'(rd_valid), 64'd0);
    for (int i = 1; i <= 5; i++) sample(32'(i), 1'b0);
    check("pre_count", 64'(count), 64'd5);
    sample(32'h6, 1'b1);
    check("trig_state", 64'(state), 64'd2);
    sample(32'h7, 1'b1);
    check("post_trig_ign", 64'(state), 64'd2);
    sample(32'h8, 1'b0);
    check("done_state", 64'(state), 64'd3);
    check("done_count", 64'(count), 64'd8);
    check("done_wrap", 64'(wrapped), 64'd0);
    read_run("r1", 8, 32'h1);
    check("r1_cnt0", 64'(count), 64'd0);
    tick();
    check("r1_idle", 64'(state), 64'd0);
    check("r1_vld0", 64'(rd_valid), 64'd0);

    // Wrap: trigger on 0xA, done after 0xC
    do_arm();
    for (int i = 1; i <= 12; i++) sample(32'(i), i == 10);
    check("w_state", 64'(state), 64'd3);
    check("w_wrap", 64'(wrapped), 64'd1);
    check("w_count", 64'(count), 64'd8);
    read_run("r2", 8, 32'h5);
    tick();
    check("r2_idle", 64'(state), 64'd0);

    // Reset during POST abandons capture
    do_arm();
    sample(32'h11, 1'b0);
    sample(32'h12, 1'b0);
    sample(32'h13, 1'b1);
    check("p_state", 64'(state), 64'd2);
    check("p_count", 64'(count), 64'd3);
    arm = 1'b1;
    do_reset();
    arm = 1'b0;
    check("p_rst_state", 64'(state), 64'd0);
    check("p_rst_count", 64'(count), 64'd0);
    do_arm();
    sample(32'h21, 1'b0);
    sample(32'h22, 1'b1);
    sample(32'h23, 1'b0);
    sample(32'h24, 1'b0);
    check("p2_state", 64'(state), 64'd3);
    check("p2_count", 64'(count), 64'd4);
    read_run("r3", 4, 32'h21);
    tick();
    check("r3_idle", 64'(state), 64'd0);

    // Arm during readout restarts capture
    do_arm();
    for (int i = 1; i <= 8; i++) sample(32'h30 + 32'(i), i == 6);
    check("a_state", 64'(state), 64'd3);
    read_run("r4", 2, 32'h31);
    check("a_count6", 64'(count), 64'd6);
    do_arm();
    check("a_rearm_state", 64'(state), 64'd1);
    check("a_rearm_count", 64'(count), 64'd0);
    check("a_rearm_vld", 64'(rd_valid), 64'd0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("a_no_vld", 64'(rd_valid), 64'd0);
    check("a_still_armed", 64'(state), 64'd1);

`ifdef TRACE_TIMESTAMP_EN
    // Stamps: arm is cycle 0, samples on cycles 3 and 7
    do_arm();
    tick();
    tick();
    sample(32'h41, 1'b0);
    tick();
    tick();
    tick();
    sample(32'h42, 1'b1);
    sample(32'h43, 1'b0);
    sample(32'h44, 1'b0);
    check("ts_state", 64'(state), 64'd3);
    rd_req = 1'b1;
    tick();
    check("ts_first", 64'(rd_data[47:32]), 64'd3);
    tick();
    check("ts_second", 64'(rd_data[47:32]), 64'd7);
    tick();
    tick();
    rd_req = 1'b0;
    check("ts_last", 64'(rd_data[47:32]), 64'd9);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
